// File: rtl/thermo_pkg.sv
// Shared state/mode encodings and setpoint constants for the thermostat controller.
package thermo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAT    = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  localparam int SET_DEFAULT_F = 72;
  localparam int SET_MIN_F     = 50;
  localparam int SET_MAX_F     = 90;
  localparam int HYST_F        = 2;

  // Lower hysteresis threshold, floored at zero instead of wrapping.
  function automatic logic [8:0] sat_sub9(input logic [7:0] a, input logic [8:0] b);
    return ({1'b0, a} >= b) ? ({1'b0, a} - b) : 9'd0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, counting from reset.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)      cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/thermostat_controller.sv
// Thermostat sequencer: setpoint buttons, sample capture, hysteresis FSM with run/lockout dwell.
// Define THERMO_WDOG_EN to build the sensor watchdog that forces LOCKOUT on stale samples.
module thermostat_controller
  import thermo_pkg::*;
#(
  parameter int SET_DEFAULT   = SET_DEFAULT_F,
  parameter int SET_MIN       = SET_MIN_F,
  parameter int SET_MAX       = SET_MAX_F,
  parameter int HYST          = HYST_F,
  parameter int TICK_DIV      = 100_000_000,
  parameter int MIN_RUN_TICKS = 60,
  parameter int MIN_OFF_TICKS = 120,
  parameter int WDOG_TICKS    = 10
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] mode,
  input  logic       temp_valid,
  input  logic [7:0] temp_f,
  output logic [7:0] set_temp,
  output logic [7:0] cur_temp,
  output logic       heat_on,
  output logic       cool_on,
  output logic       fan_on,
  output logic [1:0] ctl_state,
  output logic       sensor_fault
);
  localparam int DWELL_MAX = (MIN_RUN_TICKS > MIN_OFF_TICKS) ? MIN_RUN_TICKS : MIN_OFF_TICKS;
  localparam int DW = $clog2(DWELL_MAX + 2);

  state_t        state, state_nx;
  logic [2:0]    up_sync, dn_sync;
  logic          up_edge, dn_edge;
  logic          have_sample, tick, fault;
  logic [8:0]    cur9, lo9, hi9;
  logic [DW-1:0] dwell;
  logic          run_done, off_done, heat_mode, cool_mode;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .tick      (tick)
  );

  // Two flops resynchronise the async buttons; the third gives the rising-edge history.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[1:0], btn_up};
      dn_sync <= {dn_sync[1:0], btn_down};
    end
  end

  assign up_edge = up_sync[1] & ~up_sync[2];
  assign dn_edge = dn_sync[1] & ~dn_sync[2];

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      set_temp    <= 8'(SET_DEFAULT);
      cur_temp    <= '0;
      have_sample <= 1'b0;
    end else begin
      if (up_edge && !dn_edge && set_temp < 8'(SET_MAX))
        set_temp <= set_temp + 8'd1;
      else if (dn_edge && !up_edge && set_temp > 8'(SET_MIN))
        set_temp <= set_temp - 8'd1;
      if (temp_valid) begin
        cur_temp    <= temp_f;
        have_sample <= 1'b1;
      end
    end
  end

  assign cur9 = {1'b0, cur_temp};
  assign lo9  = sat_sub9(set_temp, 9'(HYST));
  assign hi9  = {1'b0, set_temp} + 9'(HYST);

  assign heat_mode = (mode == MODE_HEAT) || (mode == MODE_AUTO);
  assign cool_mode = (mode == MODE_COOL) || (mode == MODE_AUTO);
  assign run_done  = (dwell >= DW'(MIN_RUN_TICKS));
  assign off_done  = (dwell >= DW'(MIN_OFF_TICKS));

`ifdef THERMO_WDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  logic [WW-1:0] wdog_cnt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
    end else if (temp_valid) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
    end else if (tick && wdog_cnt < WW'(WDOG_TICKS)) begin
      wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt == WW'(WDOG_TICKS - 1)) fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign sensor_fault = fault;

  // state   | meaning
  // IDLE    | no demand, waiting for a sample outside the band
  // HEAT    | heater and fan on, minimum run enforced
  // COOL    | cooler and fan on, minimum run enforced
  // LOCKOUT | equipment rest; mode ignored until MIN_OFF_TICKS
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (have_sample && !fault) begin
          if (heat_mode && cur9 < lo9)      state_nx = ST_HEAT;
          else if (cool_mode && cur9 > hi9) state_nx = ST_COOL;
        end
      ST_HEAT:
        if (mode == MODE_OFF || fault ||
            (run_done && (cur_temp >= set_temp || mode == MODE_COOL)))
          state_nx = ST_LOCKOUT;
      ST_COOL:
        if (mode == MODE_OFF || fault ||
            (run_done && (cur_temp <= set_temp || mode == MODE_HEAT)))
          state_nx = ST_LOCKOUT;
      ST_LOCKOUT:
        if (off_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state   <= ST_IDLE;
      dwell   <= '0;
      heat_on <= 1'b0;
      cool_on <= 1'b0;
      fan_on  <= 1'b0;
    end else begin
      state   <= state_nx;
      heat_on <= (state_nx == ST_HEAT);
      cool_on <= (state_nx == ST_COOL);
      fan_on  <= (state_nx == ST_HEAT) || (state_nx == ST_COOL);
      if (state_nx != state)
        dwell <= '0;
      else if (tick && dwell < DW'(DWELL_MAX))
        dwell <= dwell + 1'b1;
    end
  end

  assign ctl_state = state;

endmodule

// File: tb/tb_thermostat_controller.sv
// Directed + randomized bench for thermostat_controller against a tick-arithmetic reference model.
module tb_thermostat_controller;
  localparam int TICK_DIV = 10;
  localparam int MIN_RUN  = 3;
  localparam int MIN_OFF  = 5;
  localparam int WDOG     = 4;
  localparam int HYST     = 2;

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN, btn_up, btn_down, temp_valid;
  logic [1:0] mode;
  logic [7:0] temp_f;
  logic [7:0] set_temp, cur_temp;
  logic       heat_on, cool_on, fan_on, sensor_fault;
  logic [1:0] ctl_state;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int sp_model = 72;

  thermostat_controller #(
    .TICK_DIV(TICK_DIV), .MIN_RUN_TICKS(MIN_RUN), .MIN_OFF_TICKS(MIN_OFF), .WDOG_TICKS(WDOG)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn_up(btn_up), .btn_down(btn_down),
    .mode(mode), .temp_valid(temp_valid), .temp_f(temp_f), .set_temp(set_temp),
    .cur_temp(cur_temp), .heat_on(heat_on), .cool_on(cool_on), .fan_on(fan_on),
    .ctl_state(ctl_state), .sensor_fault(sensor_fault)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Rising edges since reset release; a prescaler tick lands on every edge divisible by TICK_DIV.
  always @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) edges <= 0;
    else             edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic chk_out(input string tag, input int st);
    chk({tag, ".state"}, ctl_state, st);
    chk({tag, ".heat"}, heat_on, int'(st == 1));
    chk({tag, ".cool"}, cool_on, int'(st == 2));
    chk({tag, ".fan"},  fan_on,  int'(st == 1 || st == 2));
  endtask

  function automatic int idle_next(input int m, input int t, input int sp);
    int lo, hi;
    lo = (sp - HYST < 0) ? 0 : sp - HYST;
    hi = sp + HYST;
    if ((m == 1 || m == 3) && t < lo) return 1;
    if ((m == 2 || m == 3) && t > hi) return 2;
    return 0;
  endfunction

  // Edge at which a state entered at edge e0 leaves once n ticks have accumulated.
  function automatic int tick_exit(input int e0, input int n);
    int e = e0;
    int c = 0;
    while (c < n) begin
      e++;
      if (e % TICK_DIV == 0) c++;
    end
    return e + 1;
  endfunction

  task automatic press(input bit up, input bit dn, input string tag);
    btn_up = up; btn_down = dn;
    step(4);
    btn_up = 1'b0; btn_down = 1'b0;
    step(4);
    if (up && !dn)      sp_model = (sp_model < 90) ? sp_model + 1 : 90;
    else if (dn && !up) sp_model = (sp_model > 50) ? sp_model - 1 : 50;
    chk(tag, set_temp, sp_model);
  endtask

  task automatic send(input int t, input int pre, input int exp, input string tag);
    temp_valid = 1'b1; temp_f = 8'(t);
    step(1);
    temp_valid = 1'b0;
    chk({tag, ".cur"}, cur_temp, t);
    chk({tag, ".flt"}, sensor_fault, 0);
    chk({tag, ".pre"}, ctl_state, pre);
    step(1);
    chk_out(tag, exp);
  endtask

  task automatic wait_for(input int target, input int exp_edge, input string tag);
    for (int n = 0; n < 400 && ctl_state !== 2'(target); n++) step(1);
    chk({tag, ".edge"}, edges, exp_edge);
    chk_out(tag, target);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, l, v, t1, m, t, r;
    CPU_RESETN = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    mode = 2'b00; temp_valid = 1'b0; temp_f = 8'd0;
    step(3);
    chk("rst.set", set_temp, 72);
    chk("rst.cur", cur_temp, 0);
    chk("rst.flt", sensor_fault, 0);
    chk_out("rst", 0);
    CPU_RESETN = 1'b1;
    step(2);

    // Button latency: rise before edge k, setpoint moves at edge k+2.
    btn_up = 1'b1;
    step(2);
    chk("btn.lat2", set_temp, 72);
    step(1);
    chk("btn.lat3", set_temp, 73);
    step(1);
    btn_up = 1'b0;
    step(4);
    sp_model = 73;
    for (int i = 0; i < 24; i++) press(1'b1, 1'b0, "btn.up");
    chk("btn.max", set_temp, 90);
    for (int i = 0; i < 45; i++) press(1'b0, 1'b1, "btn.dn");
    chk("btn.min", set_temp, 50);
    press(1'b1, 1'b1, "btn.both");
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(2, 0);
      press(r != 1, r != 0, "btn.rnd");
    end
    while (sp_model < 72) press(1'b1, 1'b0, "btn.norm");
    while (sp_model > 72) press(1'b0, 1'b1, "btn.norm");

    // No decisions before the first sample even though cur_temp=0 is below the band.
    mode = 2'b11;
    step(4);
    chk_out("nosample", 0);

    send(69, 0, 1, "heat");
    e = edges;
    send(72, 1, 1, "heat.reach");
    wait_for(3, tick_exit(e, MIN_RUN), "heat.lock");
    l = edges;
    wait_for(0, tick_exit(l, MIN_OFF), "lock.idle");

    mode = 2'b10;
    send(75, 0, 2, "cool");
    e = edges;
    t1 = tick_exit(e, 1) - 1;
    for (int n = 0; n < 50 && edges < t1; n++) step(1);
    mode = 2'b00;
    step(1);
    chk("cool.off.edge", edges, t1 + 1);
    chk_out("cool.off", 3);
    wait_for(0, tick_exit(edges, MIN_OFF), "cool.idle");

    send(72, 0, 0, "neutral");
    mode = 2'b11;
    send(71, 0, idle_next(3, 71, sp_model), "hyst71");
    send(73, 0, idle_next(3, 73, sp_model), "hyst73");
    send(70, 0, idle_next(3, 70, sp_model), "hyst70");
    send(74, 0, idle_next(3, 74, sp_model), "hyst74");
    mode = 2'b10;
    send(69, 0, idle_next(2, 69, sp_model), "cool69");

`ifndef THERMO_WDOG_EN
    // Raising the setpoint past the band triggers HEAT one edge after set_temp moves.
    mode = 2'b00;
    send(72, 0, 0, "sp.neutral");
    mode = 2'b01;
    press(1'b1, 1'b0, "sp.up1");
    chk_out("sp.up1", 0);
    press(1'b1, 1'b0, "sp.up2");
    chk_out("sp.up2", 0);
    btn_up = 1'b1;
    for (int n = 0; n < 10 && set_temp == 8'(sp_model); n++) step(1);
    sp_model++;
    chk("sp.up3", set_temp, sp_model);
    e = edges;
    step(1);
    chk("sp.trig.edge", edges, e + 1);
    chk_out("sp.trig", 1);
    btn_up = 1'b0;
    mode = 2'b00;
    step(1);
    chk_out("sp.off", 3);
    wait_for(0, tick_exit(edges, MIN_OFF), "sp.idle");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, "sp.back");
`endif

    for (int i = 0; i < 10; i++) begin
      mode = 2'b00;
      send(72, 0, 0, "rnd.neutral");
      m = $urandom_range(3, 0);
      t = $urandom_range(84, 60);
      mode = 2'(m);
      step(2);
      chk("rnd.hold", ctl_state, 0);
      e = idle_next(m, t, sp_model);
      send(t, 0, e, "rnd");
      if (e != 0) begin
        mode = 2'b00;
        step(1);
        chk_out("rnd.off", 3);
        wait_for(0, tick_exit(edges, MIN_OFF), "rnd.idle");
      end
    end

    // Asynchronous reset in the middle of HEAT.
    mode = 2'b00;
    send(72, 0, 0, "rst.neutral");
    mode = 2'b11;
    send(60, 0, 1, "rst.heat");
    step(3);
    #2 CPU_RESETN = 1'b0;
    #1;
    chk_out("rst.async", 0);
    chk("rst.async.set", set_temp, 72);
    chk("rst.async.cur", cur_temp, 0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    sp_model = 72;
    step(5);
    chk_out("rst.nosample", 0);
    send(60, 0, 1, "rst.restart");
    mode = 2'b00;
    step(1);
    chk_out("rst.off", 3);
    wait_for(0, tick_exit(edges, MIN_OFF), "rst.idle");

`ifdef THERMO_WDOG_EN
    send(72, 0, 0, "wd.neutral");
    mode = 2'b11;
    send(60, 0, 1, "wd.heat");
    v = edges - 1;
    wait_for(3, tick_exit(v, WDOG), "wd.lock");
    chk("wd.flt", sensor_fault, 1);
    wait_for(0, tick_exit(edges, MIN_OFF), "wd.idle");
    step(5);
    chk_out("wd.block", 0);
    chk("wd.flt.hold", sensor_fault, 1);
    send(60, 0, 1, "wd.clear");
`else
    v = 0;
    chk("nowd.flt", sensor_fault, v);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
